// File: rtl/binom_stream_ctrl_pkg.sv
// Shared definitions for the binomial sampler stream controller.
// Holds the sampler mode encoding, the per-mode k / modulus lookups,
// the modulus constants, the controller FSM state type and a popcount helper.
package binom_stream_ctrl_pkg;

    localparam logic [15:0] Q_3329  = 16'd3329;
    localparam logic [15:0] Q_8192  = 16'd8192;
    localparam logic [15:0] Q_12289 = 16'd12289;

    // Codes 101..110..111 are not named; they decode like MODE_K8.
    typedef enum logic [2:0] {
        MODE_K2 = 3'b000,
        MODE_K3 = 3'b001,
        MODE_K4 = 3'b010,
        MODE_K5 = 3'b011,
        MODE_K8 = 3'b100
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits per operand for a given mode.
    function automatic logic [3:0] mode_k(input logic [2:0] m);
        logic [3:0] k;
        case (m)
            MODE_K2: k = 4'd2;
            MODE_K3: k = 4'd3;
            MODE_K4: k = 4'd4;
            MODE_K5: k = 4'd5;
            default: k = 4'd8;
        endcase
        return k;
    endfunction

    // Coefficient modulus for a given mode.
    function automatic logic [15:0] mode_modulus(input logic [2:0] m);
        logic [15:0] q;
        case (m)
            MODE_K2:                   q = Q_3329;
            MODE_K3, MODE_K4, MODE_K5: q = Q_8192;
            default:                   q = Q_12289;
        endcase
        return q;
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/binom_stream_ctrl_if.sv
// Random-word stream and coefficient write port of binom_stream_ctrl.
//   rnd_valid_i / rnd_data_i / rnd_ready_o : 32-bit random-word stream
//   coef_we_o / coef_addr_o / coef_wdata_o : coefficient-pair write port
// Handshake: a word transfers on a rising clock edge where rnd_valid_i and
// rnd_ready_o are both 1. Once raised, valid and data stay stable until the
// transfer. rnd_ready_o never depends combinationally on rnd_valid_i.
// The write port has no back-pressure: every coef_we_o cycle is one write.
interface binom_stream_ctrl_if #(
    parameter int N_PAIRS = 128
) ();
    logic                       rnd_valid_i;
    logic [31:0]                rnd_data_i;
    logic                       rnd_ready_o;
    logic                       coef_we_o;
    logic [$clog2(N_PAIRS)-1:0] coef_addr_o;
    logic [31:0]                coef_wdata_o;

    modport slave (
        input  rnd_valid_i, rnd_data_i,
        output rnd_ready_o, coef_we_o, coef_addr_o, coef_wdata_o
    );

    modport master (
        output rnd_valid_i, rnd_data_i,
        input  rnd_ready_o, coef_we_o, coef_addr_o, coef_wdata_o
    );
endinterface

// File: rtl/binom_stream_ctrl_sample.sv
// binom_sample: combinational centered-binomial sampler for one pair.
//   in_1_i  : a0 in [7:0], a1 in [23:16], all other bits 0
//   in_2_i  : b0 in [7:0], b1 in [23:16], all other bits 0
//   q_i     : modulus
//   coef_o  : {coef_hi, coef_lo}, each (popcount(a) - popcount(b)) mod q
module binom_sample
    import binom_stream_ctrl_pkg::*;
(
    input  logic [31:0] in_1_i,
    input  logic [31:0] in_2_i,
    input  logic [15:0] q_i,
    output logic [31:0] coef_o
);
    logic [4:0]  pa_lo, pb_lo, pa_hi, pb_hi;
    logic [15:0] coef_lo, coef_hi;

    // Unused operand bits are zero, so counting whole halves is exact.
    assign pa_lo = popcount16(in_1_i[15:0]);
    assign pb_lo = popcount16(in_2_i[15:0]);
    assign pa_hi = popcount16(in_1_i[31:16]);
    assign pb_hi = popcount16(in_2_i[31:16]);

    // A negative difference wraps to q - |diff|.
    assign coef_lo = (pa_lo >= pb_lo) ? 16'(pa_lo - pb_lo) : q_i - 16'(pb_lo - pa_lo);
    assign coef_hi = (pa_hi >= pb_hi) ? 16'(pa_hi - pb_hi) : q_i - 16'(pb_hi - pa_hi);

    assign coef_o = {coef_hi, coef_lo};
endmodule

// File: rtl/binom_stream_ctrl.sv
// binom_stream_ctrl: pulls 32-bit random words into a bit buffer, slices
// 4k bits per fire into two (a,b) operand pairs, samples them through
// binom_sample and writes N_PAIRS coefficient pairs to consecutive addresses.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   start_i, mode_i   : start pulse and sampler mode (latched on start)
//   bus (slave)       : random-word stream in, coefficient write port out
//   busy_o, done_o    : busy in RUN/DONE, done pulse with the last write
//   state_o           : current FSM state
module binom_stream_ctrl
    import binom_stream_ctrl_pkg::*;
#(
    parameter int N_PAIRS = 128,
    parameter int BUF_W   = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [2:0]          mode_i,
    binom_stream_ctrl_if.slave  bus,
    output logic                busy_o,
    output logic                done_o,
    output state_t              state_o
);
    localparam int AW     = $clog2(N_PAIRS);
    localparam int FILL_W = $clog2(BUF_W + 1);

    state_t             state_q, state_d;
    logic [2:0]         mode_q, mode_d;
    logic [BUF_W-1:0]   bits_q, bits_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic [3:0]         k;
    logic [15:0]        q;
    logic [FILL_W-1:0]  step;
    logic [7:0]         mask, a0, b0, a1, b1;
    logic [31:0]        in_1, in_2, sample_out;
    logic [15:0]        need;
    logic               fire, rnd_ready, accept;
    logic [BUF_W-1:0]   base;
    logic [FILL_W-1:0]  pos;

    assign k    = mode_k(mode_q);
    assign q    = mode_modulus(mode_q);
    assign step = FILL_W'({k, 2'b00});
    assign mask = 8'((9'd1 << k) - 9'd1);

    // Bits the remaining pairs still need. Once the buffer holds them all,
    // further words would only be discarded, so ready drops and a polynomial
    // consumes exactly 4k*N_PAIRS/32 words.
    assign need = 16'((AW+1)'(N_PAIRS) - (AW+1)'(cnt_q)) * 16'(step);

    assign fire      = (state_q == ST_RUN) && (fill_q >= step);
    assign rnd_ready = (state_q == ST_RUN) && (fill_q <= FILL_W'(BUF_W - 32))
                       && (16'(fill_q) < need);
    assign accept    = rnd_ready && bus.rnd_valid_i;

    // Operand slices, LSB consumed first.
    assign a0   = bits_q[7:0] & mask;
    assign b0   = 8'(bits_q >> k) & mask;
    assign a1   = 8'(bits_q >> {k, 1'b0}) & mask;
    assign b1   = 8'(bits_q >> (6'({k, 1'b0}) + 6'(k))) & mask;
    assign in_1 = {8'd0, a1, 8'd0, a0};
    assign in_2 = {8'd0, b1, 8'd0, b0};

    binom_sample u_sample (
        .in_1_i (in_1),
        .in_2_i (in_2),
        .q_i    (q),
        .coef_o (sample_out)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        bits_d  = bits_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        base    = bits_q;
        pos     = fill_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    mode_d  = mode_i;
                    bits_d  = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (fire) begin
                    base = bits_q >> step;
                    pos  = fill_q - step;
                end
                // A new word lands directly above the bits that survive this cycle.
                bits_d = accept ? (base | (BUF_W'(bus.rnd_data_i) << pos)) : base;
                fill_d = accept ? (pos + FILL_W'(32)) : pos;
                if (fire) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q;
                    wdata_d = sample_out;
                    cnt_d   = cnt_q + AW'(1);
                    if (cnt_q == AW'(N_PAIRS - 1)) begin
                        state_d = ST_DONE;
                        bits_d  = '0;
                        fill_d  = '0;
                        cnt_d   = '0;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            bits_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            bits_q  <= bits_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.rnd_ready_o  = rnd_ready;
    assign bus.coef_we_o    = we_q;
    assign bus.coef_addr_o  = addr_q;
    assign bus.coef_wdata_o = wdata_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign done_o           = (state_q == ST_DONE);
    assign state_o          = state_q;
endmodule

// File: tb/tb_binom_stream_ctrl.sv
// Bench for binom_stream_ctrl: directed vector table plus hand-written
// sequences (held valid, random gaps, ignored start, mid-run reset).
// Expected write data comes from a bit-stream model of the fed words.
module tb_binom_stream_ctrl;
    import binom_stream_ctrl_pkg::*;

    localparam int N_PAIRS = 128;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic start_i;
    logic [2:0] mode_i;
    logic busy_o, done_o;
    state_t state_o;

    always #5 clk = ~clk;

    binom_stream_ctrl_if #(.N_PAIRS(N_PAIRS)) bus ();

    binom_stream_ctrl #(.N_PAIRS(N_PAIRS), .BUF_W(64)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start_i),
        .mode_i  (mode_i),
        .bus     (bus),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .state_o (state_o)
    );

    // ---------------- bookkeeping ----------------
    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] src_words[$];
    int          src_idx;
    bit          feed_en;
    int          feed_gap;
    bit          acc_flag;

    int          acc_cnt, wr_cnt, done_cnt, done_ok, viol, cur_step;
    logic [6:0]  got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] exp_q[$];

    typedef struct {
        logic [2:0]  mode;
        logic [31:0] word;
        int          pair;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int tb_k(input logic [2:0] m);
        case (m)
            3'b000:  return 2;
            3'b001:  return 3;
            3'b010:  return 4;
            3'b011:  return 5;
            default: return 8;
        endcase
    endfunction

    function automatic int tb_q(input logic [2:0] m);
        case (m)
            3'b000:                 return 3329;
            3'b001, 3'b010, 3'b011: return 8192;
            default:                return 12289;
        endcase
    endfunction

    function automatic int stream_bit(input int idx);
        logic [31:0] w;
        if (idx / 32 >= src_words.size()) return 0;
        w = src_words[idx / 32];
        return int'(w[idx % 32]);
    endfunction

    // Pair n uses stream bits [4k*n, 4k*n+4k): a0, b0, a1, b1 in that order.
    function automatic logic [31:0] model_pair(input logic [2:0] m, input int n);
        int kk, qq, base, d_lo, d_hi;
        int pc[4];
        kk   = tb_k(m);
        qq   = tb_q(m);
        base = n * 4 * kk;
        for (int j = 0; j < 4; j++) begin
            pc[j] = 0;
            for (int b = 0; b < kk; b++) pc[j] += stream_bit(base + j * kk + b);
        end
        d_lo = pc[0] - pc[1];
        d_hi = pc[2] - pc[3];
        if (d_lo < 0) d_lo += qq;
        if (d_hi < 0) d_hi += qq;
        return {d_hi[15:0], d_lo[15:0]};
    endfunction

    // ---------------- driver / monitor ----------------
    task automatic feeder_loop();
        bus.rnd_valid_i = 1'b0;
        bus.rnd_data_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (acc_flag) src_idx++;
            if (feed_en && src_idx < src_words.size() && $urandom_range(99) >= feed_gap) begin
                bus.rnd_valid_i = 1'b1;
                bus.rnd_data_i  = src_words[src_idx];
            end else begin
                bus.rnd_valid_i = 1'b0;
                bus.rnd_data_i  = $urandom;
            end
        end
    endtask

    task automatic monitor_loop();
        int fill_m;
        forever begin
            @(negedge clk);
            if (bus.coef_we_o) begin
                got_addr.push_back(bus.coef_addr_o);
                got_data.push_back(bus.coef_wdata_o);
                wr_cnt++;
            end
            if (done_o) begin
                done_cnt++;
                if (bus.coef_we_o && bus.coef_addr_o == 7'(N_PAIRS - 1)) done_ok++;
            end
            fill_m = 32 * acc_cnt - cur_step * wr_cnt;
            if (bus.rnd_ready_o && fill_m > 32) viol++;
            acc_flag = bus.rnd_valid_i && bus.rnd_ready_o;
            if (acc_flag) acc_cnt++;
        end
    endtask

    // One polynomial. abort_after > 0 returns once that many writes are seen.
    task automatic run_poly(input logic [2:0] mode, input logic [31:0] w0, input int gap,
                            input bit poke, input int abort_after);
        int kk, cyc, errs;
        bit poked;
        kk = tb_k(mode);
        src_words.delete();
        src_words.push_back(w0);
        for (int i = 1; i < 16 * kk + 4; i++) src_words.push_back($urandom);
        src_idx = 0; acc_cnt = 0; wr_cnt = 0; done_cnt = 0; done_ok = 0; viol = 0;
        got_addr.delete(); got_data.delete();
        cur_step = 4 * kk;
        feed_gap = gap;
        feed_en  = 1'b1;
        start_i = 1'b1;
        mode_i  = mode;
        @(posedge clk); #1;
        start_i = 1'b0;
        mode_i  = ~mode;
        cyc = 0; poked = 1'b0;
        while (done_cnt == 0 && cyc < 4000 && !(abort_after > 0 && wr_cnt >= abort_after)) begin
            @(posedge clk); #1;
            cyc++;
            start_i = 1'b0;
            if (poke && !poked && wr_cnt >= 10) begin
                start_i = 1'b1;
                mode_i  = 3'b000;
                poked   = 1'b1;
            end
        end
        if (abort_after > 0) return;
        feed_en = 1'b0;
        check("done_seen", 32'(done_cnt > 0), 32'd1);
        check("write_count", 32'(wr_cnt), 32'(N_PAIRS));
        check("done_count", 32'(done_cnt), 32'd1);
        check("done_with_last_write", 32'(done_ok), 32'd1);
        check("words_accepted", 32'(acc_cnt), 32'(16 * kk));
        check("ready_while_fill_gt_32", 32'(viol), 32'd0);
        errs = 0;
        foreach (got_addr[i]) if (got_addr[i] != 7'(i)) errs++;
        check("addr_sequence", 32'(errs), 32'd0);
        exp_q.delete();
        for (int n = 0; n < N_PAIRS; n++) exp_q.push_back(model_pair(mode, n));
        errs = 0;
        foreach (got_data[i]) begin
            if (exp_q.size() == 0 || got_data[i] !== exp_q.pop_front()) errs++;
        end
        check("model_wdata_mismatches", 32'(errs), 32'd0);
        @(negedge clk);
        check("ready_after_done", 32'(bus.rnd_ready_o), 32'd0);
        check("busy_after_done", 32'(busy_o), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(bus.rnd_ready_o), 32'd0);
        check({tag, "_we"},    32'(bus.coef_we_o), 32'd0);
        check({tag, "_addr"},  32'(bus.coef_addr_o), 32'd0);
        check({tag, "_wdata"}, bus.coef_wdata_o, 32'd0);
        check({tag, "_busy"},  32'(busy_o), 32'd0);
        check({tag, "_done"},  32'(done_o), 32'd0);
        check({tag, "_state"}, 32'(state_o), 32'(ST_IDLE));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_n = 1'b0; start_i = 1'b0; mode_i = 3'b000;
        feed_en = 1'b0; feed_gap = 0; acc_flag = 1'b0; src_idx = 0;
        acc_cnt = 0; wr_cnt = 0; done_cnt = 0; done_ok = 0; viol = 0; cur_step = 8;

        vecs[0] = '{3'b000, 32'h0000_0003, 0, 32'h0000_0002, "m0_w03_pair0"};
        vecs[1] = '{3'b000, 32'h0000_0003, 1, 32'h0000_0000, "m0_w03_pair1"};
        vecs[2] = '{3'b000, 32'h0000_000C, 0, 32'h0000_0CFF, "m0_w0c_pair0"};
        vecs[3] = '{3'b000, 32'h0000_0030, 0, 32'h0002_0000, "m0_w30_pair0"};
        vecs[4] = '{3'b100, 32'h0000_FF00, 0, 32'h0000_2FF9, "m4_wff00_pair0"};
        vecs[5] = '{3'b001, 32'h0000_0E07, 0, 32'h1FFD_0003, "m1_we07_pair0"};
        vecs[6] = '{3'b010, 32'h0000_F00F, 0, 32'h1FFC_0004, "m2_wf00f_pair0"};
        vecs[7] = '{3'b011, 32'h000F_FC1F, 0, 32'h0000_0005, "m3_wffc1f_pair0"};
        vecs[8] = '{3'b111, 32'h0F0F_FF01, 0, 32'h0000_2FFA, "m7_w0f0fff01_pair0"};

        fork
            feeder_loop();
            monitor_loop();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_poly(vecs[i].mode, vecs[i].word, 0, 1'b0, 0);
            check(vecs[i].name,
                  (got_data.size() > vecs[i].pair) ? got_data[vecs[i].pair] : 32'hDEAD_BEEF,
                  vecs[i].exp);
        end

        // Mode 001 with valid held high: 48 words, 128 writes.
        run_poly(3'b001, $urandom, 0, 1'b0, 0);
        // Mode 011 with random valid gaps.
        run_poly(3'b011, $urandom, 40, 1'b0, 0);
        // A start pulse mid-run must not disturb the polynomial.
        run_poly(3'b010, $urandom, 20, 1'b1, 0);

        // Reset after 50 writes, asserted between clock edges.
        run_poly(3'b100, $urandom, 0, 1'b0, 50);
        check("writes_before_reset", 32'(wr_cnt >= 50), 32'd1);
        #2;
        rst_n   = 1'b0;
        feed_en = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_poly(3'b100, 32'h0000_FF00, 10, 1'b0, 0);
        check("restart_pair0", (got_data.size() > 0) ? got_data[0] : 32'hDEAD_BEEF, 32'h0000_2FF9);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/binom_stream_ctrl.md
BINOM_STREAM_CTRL -- requirements
Module: binom_stream_ctrl

Interface
REQ-001 Parameter N_PAIRS, default 128, coefficient pairs per polynomial (256 coefficients).
REQ-002 Parameter BUF_W, default 64, bit-buffer width.
REQ-003 clk_i  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 start_i  input  1  one-cycle pulse that begins sampling one polynomial.
REQ-006 mode_i  input  3  sampler mode, sampled on start_i.
REQ-007 rnd_valid_i / rnd_data_i / rnd_ready_o  in/in/out  1/32/1  random-word stream; a word transfers when valid and ready are both 1.
REQ-008 coef_we_o  output  1  coefficient-pair write strobe.
REQ-009 coef_addr_o  output  $clog2(N_PAIRS)  pair index.
REQ-010 coef_wdata_o  output  32  {coef_hi[15:0], coef_lo[15:0]}.
REQ-011 busy_o / done_o  output  1/1  busy is 1 while sampling; done is a one-cycle pulse at the end.

Function
REQ-012 Mode decode: 000 -> k=2, q=3329; 001 -> k=3, q=8192; 010 -> k=4, q=8192; 011 -> k=5, q=8192; 100-111 -> k=8, q=12289.
REQ-013 FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start_i: latch mode, clear the buffer fill count and pair counter.
  - RUN -> DONE on the fire that writes pair N_PAIRS-1.
  - DONE -> IDLE unconditionally after one cycle.
REQ-014 start_i outside IDLE shall be ignored.
REQ-015 rnd_ready_o = (state==RUN) && (fill <= BUF_W-32); it is driven from registers only, with no combinational path from rnd_valid_i.
REQ-016 An accepted word is appended above the existing valid bits; the LSB of the buffer is consumed first.
REQ-017 A fire occurs in RUN when fill >= 4k. On a fire, take a0=buf[k-1:0], b0=buf[2k-1:k], a1=buf[3k-1:2k], b1=buf[4k-1:3k], then shift the buffer right by 4k.
REQ-018 Sampler operands: in_1 = a0 zero-extended into bits [7:0] and a1 into bits [23:16]; in_2 = b0 and b1 placed the same way; all other bits 0.
REQ-019 Coefficient = (popcount(a) - popcount(b)) mod q, in the range 0..q-1. coef_lo comes from (a0,b0); coef_hi comes from (a1,b1).
REQ-020 Write-port latency: coef_we_o/addr/wdata are registered and asserted on the cycle after the fire, for exactly one cycle per fire. Addresses increment from 0 to N_PAIRS-1 with no gaps.
REQ-021 Simultaneous accept and fire in one cycle: the next fill = fill - 4k + 32. The new word is placed at bit position fill-4k.
REQ-022 At most one fire per cycle.
REQ-023 Leftover buffer bits at DONE are discarded.
REQ-024 busy_o is 1 in RUN and DONE.
REQ-025 done_o is 1 in DONE; that cycle coincides with the final coef_we_o.

Reset
REQ-026 On reset assertion, even mid-RUN, the block shall immediately enter IDLE and clear the buffer, fill, counters and latched mode. All outputs go to 0, including rnd_ready_o, coef_we_o, addr, wdata, busy_o and done_o.
REQ-027 After deassertion the block shall wait for a fresh start_i; partial results are not resumed.

Structure
REQ-028 A shared pq package shall hold: the mode enum, the k/q lookup functions, the modulus constants 3329/8192/12289 and the FSM state typedef.
REQ-029 The existing binom_sample block shall be instantiated as the single combinational sub-module; no other sub-modules.

Verification
REQ-030 Mode 000, first word 0x00000003 -> pair 0 wdata 0x00000002. Second fire from the same word (bits 15:8 = 0) -> pair 1 wdata 0x00000000.
REQ-031 Mode 000, word 0x0000000C -> pair 0 wdata 0x00000CFF (-2 mod 3329 = 3327).
REQ-032 Mode 100, word 0x0000FF00 -> pair 0 wdata 0x00002FF9 (12281). Exactly 128 words are consumed per polynomial.
REQ-033 Mode 001 with rnd_valid_i held at 1 -> exactly 48 words accepted, 128 writes to addr 0..127, done_o high on the cycle of the addr-127 write, then rnd_ready_o = 0.
REQ-034 Random rnd_valid_i gaps in mode 011 -> write data matches a reference model bit-exactly. rnd_ready_o never asserts while fill > 32.
REQ-035 Reset asserted after 50 writes -> all outputs 0 asynchronously. A following start_i restarts at addr 0 with an empty buffer.
